// File: rtl/spi_flash_pkg.sv
// Shared definitions for the serial-flash command sequencer: FSM states,
// header length and flash opcodes.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    // Opcode + three address bytes precede the data phase.
    localparam logic [2:0] HDR_BYTES = 3'd4;

    localparam logic [7:0] FLASH_OP_READ = 8'h03;
    localparam logic [7:0] FLASH_OP_RDID = 8'h9F;

    function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                            input logic [7:0]  opcode,
                                            input logic [23:0] addr);
        logic [7:0] b;
        case (idx)
            3'd0:    b = opcode;
            3'd1:    b = addr[23:16];
            3'd2:    b = addr[15:8];
            default: b = addr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_buffer.sv
// One-entry valid/ready holding register; a write in the same cycle as a drain keeps it full.
// Zero-latency read side: data written on an edge is presented the next cycle until taken.
module spi_byte_buffer (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_vld,
    input  logic [7:0] wr_dat,
    input  logic       out_rdy,
    output logic       out_vld,
    output logic [7:0] out_dat,
    output logic       empty,
    output logic       drain
);

    logic       vld_q, vld_d;
    logic [7:0] dat_q, dat_d;

    always_comb begin
        drain = vld_q && out_rdy;
        vld_d = vld_q;
        dat_d = dat_q;
        if (drain) begin
            vld_d = 1'b0;
        end
        // A fresh byte overrides the drain so it is never lost.
        if (wr_vld) begin
            vld_d = 1'b1;
            dat_d = wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            dat_q <= 8'h00;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld = vld_q;
    assign out_dat = dat_q;
    assign empty   = !vld_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Runs one serial-flash READ (cs_n, opcode, 24-bit address, N data bytes) per accepted command.
// A full output buffer holds off the next data byte, stalling the SPI clock rather than dropping data.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter logic [7:0]  OPCODE   = FLASH_OP_READ,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned CS_DELAY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [23:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             done,
    output logic             busy,
    output logic             spi_cs_n,
    output logic [7:0]       tx_byte,
    output logic             tx_dv,
    input  logic             tx_ready,
    input  logic             rx_dv,
    input  logic [7:0]       rx_byte
);

    localparam int unsigned      CNT_W    = $clog2(CS_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CS_DELAY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       hdr_q, hdr_d;
    logic             cs_n_q, cs_n_d;

    logic             in_hdr;
    logic             buf_wr;
    logic             buf_empty;
    logic             buf_drain;

    assign in_hdr = (hdr_q < HDR_BYTES);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        hdr_d   = hdr_q;
        cs_n_d  = cs_n_q;
        tx_dv   = 1'b0;
        tx_byte = 8'h00;
        buf_wr  = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = CNT_LOAD;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    hdr_d   = 3'd0;
                    cs_n_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tx_byte = in_hdr ? hdr_byte(hdr_q, OPCODE, addr_q) : 8'h00;
                // Data bytes only go out when the buffer will be free for their rx_dv.
                if (tx_ready && (in_hdr || buf_empty || buf_drain)) begin
                    tx_dv   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rx_dv) begin
                    state_d = ST_ISSUE;
                    if (in_hdr) begin
                        hdr_d = hdr_q + 3'd1;
                        if ((hdr_q == HDR_BYTES - 3'd1) && (len_q == '0)) begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        buf_wr = 1'b1;
                        len_d  = len_q - LEN_ONE;
                        if (len_q == LEN_ONE) begin
                            state_d = ST_HOLD;
                        end
                    end
                    if (state_d == ST_HOLD) begin
                        cnt_d = CNT_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        cs_n_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            hdr_q   <= 3'd0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            hdr_q   <= hdr_d;
            cs_n_q  <= cs_n_d;
        end
    end

    spi_byte_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_vld  (buf_wr),
        .wr_dat  (rx_byte),
        .out_rdy (out_ready),
        .out_vld (out_valid),
        .out_dat (out_data),
        .empty   (buf_empty),
        .drain   (buf_drain)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a reactive SPI-master model.
module tb_spi_flash_reader;

    localparam int CS_DELAY = 4;
    localparam int LEN_W    = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [23:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic             done;
    logic             busy;
    logic             spi_cs_n;
    logic [7:0]       tx_byte;
    logic             tx_dv;
    logic             tx_ready;
    logic             rx_dv;
    logic [7:0]       rx_byte;

    always #5 clk = ~clk;

    spi_flash_reader #(
        .OPCODE   (8'h03),
        .LEN_W    (LEN_W),
        .CS_DELAY (CS_DELAY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .done      (done),
        .busy      (busy),
        .spi_cs_n  (spi_cs_n),
        .tx_byte   (tx_byte),
        .tx_dv     (tx_dv),
        .tx_ready  (tx_ready),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] tx_q[$];
    logic [7:0] out_q[$];
    logic [7:0] rx_data_q[$];
    int bt = 2;

    // SPI master model: takes tx_dv, goes busy, returns a byte after bt+1 cycles.
    initial begin
        int idx;
        idx      = 0;
        tx_ready = 1'b1;
        rx_dv    = 1'b0;
        rx_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_cs_n) idx = 0;
            if (tx_dv && tx_ready) begin
                tx_q.push_back(tx_byte);
                @(posedge clk);
                #1 tx_ready = 1'b0;
                repeat (bt) @(posedge clk);
                #1;
                rx_dv = 1'b1;
                if (idx < 4)                rx_byte = 8'hEE;
                else if (rx_data_q.size() > 0) rx_byte = rx_data_q.pop_front();
                else                        rx_byte = 8'hBD;
                idx++;
                @(posedge clk);
                #1;
                rx_dv    = 1'b0;
                tx_ready = 1'b1;
            end
        end
    end

    int cyc = 0, cs_low = 0, done_cnt = 0, acc_cnt = 0, acc_cyc = 0, done_cyc = 0;
    int ov_seen = 0, viol = 0, full_viol = 0;
    logic done_csn = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!spi_cs_n) cs_low++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_csn = spi_cs_n;
            end
            if (cmd_valid && cmd_ready) begin
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (out_valid && out_ready) out_q.push_back(out_data);
            if (out_valid) ov_seen++;
            if (tx_dv && !tx_ready) viol++;
            if (tx_dv && out_valid && !out_ready) full_viol++;
        end
    end

    task automatic start_cmd(input logic [23:0] addr, input logic [LEN_W-1:0] len);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accept", ok, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    task automatic clear_logs();
        tx_q.delete();
        out_q.delete();
        cs_low   = 0;
        done_cnt = 0;
        acc_cnt  = 0;
        ov_seen  = 0;
    endtask

    initial begin
        logic [7:0] exp1[6];
        logic [7:0] exp4[4];
        bit ok;
        int snap;
        int nd;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 24'h0;
        cmd_len   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_dv", tx_dv, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_tx_byte", tx_byte, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic read of two bytes.
        exp1 = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
        @(posedge clk);
        #1;
        clear_logs();
        bt = 2;
        rx_data_q = '{8'hAA, 8'h55};
        start_cmd(24'h123456, 16'd2);
        check("t1_busy", busy, 1);
        wait_done("t1_done", 500);
        check("t1_ready_at_done", cmd_ready, 0);
        check("t1_busy_at_done", busy, 1);
        #1;
        check("t1_cs_at_done", done_csn, 1);
        check("t1_latency", done_cyc - acc_cyc, 33);
        check("t1_cs_low", cs_low, 32);
        check("t1_tx_count", tx_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < tx_q.size()) check($sformatf("t1_tx%0d", i), tx_q[i], exp1[i]);
        @(negedge clk);
        check("t1_ready_after", cmd_ready, 1);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_out_count", out_q.size(), 2);
        if (out_q.size() == 2) begin
            check("t1_out0", out_q[0], 8'hAA);
            check("t1_out1", out_q[1], 8'h55);
        end

        // Zero-length read.
        @(posedge clk);
        #1;
        clear_logs();
        start_cmd(24'h000010, 16'd0);
        wait_done("t2_done", 500);
        check("t2_ready_at_done", cmd_ready, 0);
        #1;
        check("t2_latency", done_cyc - acc_cyc, 25);
        check("t2_cs_low", cs_low, 24);
        check("t2_tx_count", tx_q.size(), 4);
        if (tx_q.size() == 4) begin
            check("t2_tx0", tx_q[0], 8'h03);
            check("t2_tx3", tx_q[3], 8'h10);
        end
        @(negedge clk);
        check("t2_ready_after", cmd_ready, 1);
        check("t2_no_out_valid", ov_seen, 0);

        // Consumer stall for 50 cycles after the first byte.
        @(posedge clk);
        #1;
        clear_logs();
        full_viol = 0;
        out_ready = 1'b0;
        rx_data_q = '{8'h11, 8'h22, 8'h33};
        start_cmd(24'h0000A0, 16'd3);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("t3_first_byte", ok, 1);
        #1;
        cs_low = 0;
        snap   = tx_q.size();
        repeat (50) @(negedge clk);
        #1;
        check("t3_cs_held", cs_low, 50);
        check("t3_tx_frozen", tx_q.size(), snap);
        check("t3_tx_at_stall", snap, 5);
        check("t3_out_held", out_data, 8'h11);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("t3_done", 500);
        repeat (3) @(negedge clk);
        #1;
        check("t3_no_tx_when_full", full_viol, 0);
        check("t3_out_count", out_q.size(), 3);
        if (out_q.size() == 3) begin
            check("t3_out0", out_q[0], 8'h11);
            check("t3_out1", out_q[1], 8'h22);
            check("t3_out2", out_q[2], 8'h33);
        end

        // Back-to-back data with the fastest master.
        exp4 = '{8'h9A, 8'hBC, 8'hDE, 8'hF1};
        @(posedge clk);
        #1;
        clear_logs();
        bt = 0;
        rx_data_q = '{8'h9A, 8'hBC, 8'hDE, 8'hF1};
        start_cmd(24'h00FF00, 16'd4);
        wait_done("t4_done", 500);
        #1;
        check("t4_latency", done_cyc - acc_cyc, 25);
        repeat (3) @(negedge clk);
        #1;
        check("t4_out_count", out_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < out_q.size()) check($sformatf("t4_out%0d", i), out_q[i], exp4[i]);

        // Reset in the middle of data byte 2 of 5.
        @(posedge clk);
        #1;
        clear_logs();
        bt = 2;
        rx_data_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        start_cmd(24'h000200, 16'd5);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (tx_q.size() >= 6) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_reach_byte2", ok, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t5_cs_n", spi_cs_n, 1);
        check("t5_out_valid", out_valid, 0);
        check("t5_out_data", out_data, 8'h00);
        check("t5_busy", busy, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        clear_logs();
        rx_data_q.delete();
        rx_data_q.push_back(8'h5A);
        start_cmd(24'hABCDEF, 16'd1);
        wait_done("t5_new_done", 500);
        repeat (3) @(negedge clk);
        #1;
        check("t5_new_tx_count", tx_q.size(), 5);
        if (tx_q.size() == 5) begin
            check("t5_new_tx1", tx_q[1], 8'hAB);
            check("t5_new_tx3", tx_q[3], 8'hEF);
        end
        check("t5_new_out_count", out_q.size(), 1);
        if (out_q.size() == 1) check("t5_new_out0", out_q[0], 8'h5A);

        // cmd_valid held high: one accept per done.
        @(posedge clk);
        #1;
        clear_logs();
        rx_data_q = '{8'h71, 8'h72};
        cmd_addr  = 24'h000100;
        cmd_len   = 16'd1;
        cmd_valid = 1'b1;
        nd = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (nd == 2) break;
        end
        check("t6_two_done", nd, 2);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("t6_accepts", acc_cnt, 2);
        check("t6_done_cnt", done_cnt, 2);
        check("t6_out_count", out_q.size(), 2);
        if (out_q.size() == 2) begin
            check("t6_out0", out_q[0], 8'h71);
            check("t6_out1", out_q[1], 8'h72);
        end
        check("txdv_without_ready", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
